// File: rtl/ysyx_rd_arb.sv
// ysyx_rd_arb: shares one AXI4 read channel (AR/R) between IFU fetch and
// LSU load. One transaction in flight; R beats go only to the granted owner.
// Ports: clock/reset (sync, active-high), flush_pipeline,
//   ifu_* fetch request + out_ifu_* response, lsu_* load request +
//   out_lsu_* response, out_rerr, io_master_ar*/r* AXI4 master read path.
// Config: define YSYX_RD_ARB_RR_EN for round-robin arbitration in IDLE;
//   otherwise fixed priority LSU > IFU (ifu_lock overrides in both).
module ysyx_rd_arb #(
  parameter int XLEN       = 32,
  parameter int IFU_BURST  = 4,
  parameter int AXI_ID_IFU = 0,
  parameter int AXI_ID_LSU = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_pipeline,
  input  logic [XLEN-1:0] ifu_araddr,
  input  logic            ifu_arvalid,
  input  logic            ifu_lock,
  output logic            out_ifu_arready,
  output logic [XLEN-1:0] out_ifu_rdata,
  output logic            out_ifu_rvalid,
  input  logic [XLEN-1:0] lsu_araddr,
  input  logic            lsu_arvalid,
  input  logic [7:0]      lsu_rstrb,
  output logic [XLEN-1:0] out_lsu_rdata,
  output logic            out_lsu_rvalid,
  output logic            out_rerr,
  output logic [XLEN-1:0] io_master_araddr,
  output logic            io_master_arvalid,
  output logic [3:0]      io_master_arid,
  output logic [7:0]      io_master_arlen,
  output logic [2:0]      io_master_arsize,
  output logic [1:0]      io_master_arburst,
  input  logic            io_master_arready,
  input  logic [XLEN-1:0] io_master_rdata,
  input  logic            io_master_rvalid,
  input  logic            io_master_rlast,
  input  logic [1:0]      io_master_rresp,
  input  logic [3:0]      io_master_rid,
  output logic            io_master_rready
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IFU,
    OWN_LSU
  } owner_t;

  state_t          state_q;
  state_t          state_d;
  owner_t          owner_q;
  logic            last_ifu_q;
  logic            drop_q;
  logic [XLEN-1:0] araddr_q;
  logic [3:0]      arid_q;
  logic [7:0]      arlen_q;
  logic [2:0]      arsize_q;

  logic            ifu_req;
  logic            lsu_wins;
  logic            grant_ifu;
  logic            grant_lsu;
  logic [2:0]      lsu_size;

  // A flushed fetch must not even be granted.
  assign ifu_req = ifu_arvalid && !flush_pipeline;

`ifdef YSYX_RD_ARB_RR_EN
  // Tie goes to whoever did not win last; a locked IFU keeps the bus.
  assign lsu_wins = lsu_arvalid &&
                    (!ifu_req || (last_ifu_q && !ifu_lock));
`else
  assign lsu_wins = lsu_arvalid &&
                    !(ifu_req && ifu_lock && last_ifu_q);
`endif

  always_comb begin
    lsu_size = 3'd2;
    unique case (lsu_rstrb)
      8'h01:   lsu_size = 3'd0;
      8'h03:   lsu_size = 3'd1;
      8'h0f:   lsu_size = 3'd2;
      8'hff:   lsu_size = 3'd3;
      default: lsu_size = 3'd2;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    grant_ifu         = 1'b0;
    grant_lsu         = 1'b0;
    out_ifu_arready   = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    out_ifu_rvalid    = 1'b0;
    out_lsu_rvalid    = 1'b0;
    out_rerr          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!reset) begin
          grant_lsu = lsu_wins;
          grant_ifu = ifu_req && !lsu_wins;
        end
        out_ifu_arready = grant_ifu;
        if (grant_ifu || grant_lsu) state_d = ADDR;
      end
      ADDR: begin
        io_master_arvalid = 1'b1;
        if (io_master_arready) state_d = DATA;
      end
      DATA: begin
        io_master_rready = 1'b1;
        if (io_master_rvalid) begin
          if (io_master_rid != arid_q) begin
            out_rerr = 1'b1;
          end else begin
            out_rerr       = (io_master_rresp != 2'b00);
            out_ifu_rvalid = (owner_q == OWN_IFU) &&
                             !drop_q && !flush_pipeline;
            out_lsu_rvalid = (owner_q == OWN_LSU);
            if (io_master_rlast) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      last_ifu_q <= 1'b0;
      drop_q     <= 1'b0;
      araddr_q   <= '0;
      arid_q     <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
    end else begin
      if (grant_lsu) begin
        owner_q    <= OWN_LSU;
        last_ifu_q <= 1'b0;
        araddr_q   <= lsu_araddr;
        arid_q     <= 4'(AXI_ID_LSU);
        arlen_q    <= 8'd0;
        arsize_q   <= lsu_size;
      end else if (grant_ifu) begin
        owner_q    <= OWN_IFU;
        last_ifu_q <= 1'b1;
        araddr_q   <= ifu_araddr;
        arid_q     <= 4'(AXI_ID_IFU);
        arlen_q    <= 8'(IFU_BURST - 1);
        arsize_q   <= 3'd2;
      end
      // The burst still drains on AXI; only delivery is squashed.
      if (state_q != IDLE && owner_q == OWN_IFU &&
          flush_pipeline)
        drop_q <= 1'b1;
      if (state_q == DATA && state_d == IDLE) begin
        drop_q  <= 1'b0;
        owner_q <= OWN_NONE;
      end
    end
  end

  assign io_master_araddr  = araddr_q;
  assign io_master_arid    = arid_q;
  assign io_master_arlen   = arlen_q;
  assign io_master_arsize  = arsize_q;
  assign io_master_arburst = 2'b01;
  assign out_ifu_rdata     = io_master_rdata;
  assign out_lsu_rdata     = io_master_rdata;

endmodule

// File: tb/tb_ysyx_rd_arb.sv
// tb_ysyx_rd_arb: directed bench for ysyx_rd_arb with scoreboard queues
// for AR handshakes and R beats delivered to IFU/LSU.
module tb_ysyx_rd_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_pipeline;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_lock;
  logic        out_ifu_arready;
  logic [31:0] out_ifu_rdata;
  logic        out_ifu_rvalid;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic [7:0]  lsu_rstrb;
  logic [31:0] out_lsu_rdata;
  logic        out_lsu_rvalid;
  logic        out_rerr;
  logic [31:0] io_master_araddr;
  logic        io_master_arvalid;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_arready;
  logic [31:0] io_master_rdata;
  logic        io_master_rvalid;
  logic        io_master_rlast;
  logic [1:0]  io_master_rresp;
  logic [3:0]  io_master_rid;
  logic        io_master_rready;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ifu_q[$];
  logic [31:0] lsu_q[$];
  logic [48:0] ar_q[$];

  always #5 clock = ~clock;

  ysyx_rd_arb dut (
    .clock(clock),
    .reset(reset),
    .flush_pipeline(flush_pipeline),
    .ifu_araddr(ifu_araddr),
    .ifu_arvalid(ifu_arvalid),
    .ifu_lock(ifu_lock),
    .out_ifu_arready(out_ifu_arready),
    .out_ifu_rdata(out_ifu_rdata),
    .out_ifu_rvalid(out_ifu_rvalid),
    .lsu_araddr(lsu_araddr),
    .lsu_arvalid(lsu_arvalid),
    .lsu_rstrb(lsu_rstrb),
    .out_lsu_rdata(out_lsu_rdata),
    .out_lsu_rvalid(out_lsu_rvalid),
    .out_rerr(out_rerr),
    .io_master_araddr(io_master_araddr),
    .io_master_arvalid(io_master_arvalid),
    .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen),
    .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_arready(io_master_arready),
    .io_master_rdata(io_master_rdata),
    .io_master_rvalid(io_master_rvalid),
    .io_master_rlast(io_master_rlast),
    .io_master_rresp(io_master_rresp),
    .io_master_rid(io_master_rid),
    .io_master_rready(io_master_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {addr, len, size, id, burst}
  task automatic exp_ar(input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [3:0] id);
    ar_q.push_back({a, len, sz, id, 2'b01});
  endtask

  task automatic monitor();
    if (io_master_arvalid && io_master_arready) begin
      chk("ar_pending", 64'(ar_q.size() != 0), 64'd1);
      if (ar_q.size() != 0)
        chk("ar_fields",
            64'({io_master_araddr, io_master_arlen, io_master_arsize,
                 io_master_arid, io_master_arburst}),
            64'(ar_q.pop_front()));
    end
    if (out_ifu_rvalid) begin
      chk("ifu_pending", 64'(ifu_q.size() != 0), 64'd1);
      if (ifu_q.size() != 0)
        chk("ifu_rdata", 64'(out_ifu_rdata), 64'(ifu_q.pop_front()));
    end
    if (out_lsu_rvalid) begin
      chk("lsu_pending", 64'(lsu_q.size() != 0), 64'd1);
      if (lsu_q.size() != 0)
        chk("lsu_rdata", 64'(out_lsu_rdata), 64'(lsu_q.pop_front()));
    end
  endtask

  task automatic cyc();
    #1;
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  task automatic ar_accept(input int waits);
    for (int i = 0; i < waits; i++) begin
      look();
      chk("ar_hold", 64'(io_master_arvalid), 64'd1);
      cyc();
    end
    io_master_arready = 1'b1;
    look();
    chk("ar_valid", 64'(io_master_arvalid), 64'd1);
    cyc();
    io_master_arready = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last,
                      input logic [3:0] id, input logic [1:0] resp);
    io_master_rvalid = 1'b1;
    io_master_rdata  = d;
    io_master_rlast  = last;
    io_master_rid    = id;
    io_master_rresp  = resp;
    cyc();
    io_master_rvalid = 1'b0;
    io_master_rlast  = 1'b0;
    io_master_rresp  = 2'b00;
  endtask

  task automatic ifu_burst(input logic [31:0] base, input bit keep);
    for (int i = 0; i < 4; i++) begin
      if (keep) ifu_q.push_back(base + 32'(i));
      beat(base + 32'(i), i == 3, 4'd0, 2'b00);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush_pipeline = 1'b0;
    ifu_araddr = '0;
    ifu_arvalid = 1'b0;
    ifu_lock = 1'b0;
    lsu_araddr = '0;
    lsu_arvalid = 1'b0;
    lsu_rstrb = '0;
    io_master_arready = 1'b0;
    io_master_rdata = '0;
    io_master_rvalid = 1'b0;
    io_master_rlast = 1'b0;
    io_master_rresp = '0;
    io_master_rid = '0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    look();
    chk("rst_arvalid", 64'(io_master_arvalid), 64'd0);
    chk("rst_rready", 64'(io_master_rready), 64'd0);
    chk("rst_arready", 64'(out_ifu_arready), 64'd0);
    chk("rst_rvalids", 64'({out_ifu_rvalid, out_lsu_rvalid, out_rerr}),
        64'd0);
    cyc();

    // LSU-only word load, arready two cycles after arvalid
    lsu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_0010;
    lsu_rstrb = 8'h0f;
    exp_ar(32'h8000_0010, 8'd0, 3'd2, 4'd1);
    look();
    chk("lsu_no_ifu_ack", 64'(out_ifu_arready), 64'd0);
    chk("grant_ar_late", 64'(io_master_arvalid), 64'd0);
    cyc();
    lsu_arvalid = 1'b0;
    ar_accept(2);
    lsu_q.push_back(32'hDEAD_BEEF);
    look();
    chk("lsu_rready", 64'(io_master_rready), 64'd1);
    beat(32'hDEAD_BEEF, 1'b1, 4'd1, 2'b00);
    look();
    chk("post_rlast_idle", 64'({io_master_arvalid, io_master_rready}),
        64'd0);
    cyc();

    // IFU 4-beat burst
    ifu_arvalid = 1'b1;
    ifu_araddr = 32'h3000_0000;
    exp_ar(32'h3000_0000, 8'd3, 3'd2, 4'd0);
    look();
    chk("ifu_arready", 64'(out_ifu_arready), 64'd1);
    cyc();
    ifu_arvalid = 1'b0;
    look();
    chk("ifu_arready_pulse", 64'(out_ifu_arready), 64'd0);
    ar_accept(0);
    ifu_burst(32'h1000, 1'b1);

    // simultaneous requests: LSU first, IFU after the bubble
    ifu_arvalid = 1'b1;
    ifu_araddr = 32'h3000_0040;
    lsu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_0020;
    lsu_rstrb = 8'h01;
    exp_ar(32'h8000_0020, 8'd0, 3'd0, 4'd1);
    look();
    chk("tie_lsu_first", 64'(out_ifu_arready), 64'd0);
    cyc();
    lsu_arvalid = 1'b0;
    ar_accept(1);
    lsu_q.push_back(32'h1122_3344);
    beat(32'h1122_3344, 1'b1, 4'd1, 2'b00);
    exp_ar(32'h3000_0040, 8'd3, 3'd2, 4'd0);
    look();
    chk("ifu_after_lsu", 64'(out_ifu_arready), 64'd1);
    cyc();
    ifu_arvalid = 1'b0;

    // flush after beat 1: beats 2,3 drained but not delivered
    ar_accept(0);
    ifu_q.push_back(32'h2000);
    beat(32'h2000, 1'b0, 4'd0, 2'b00);
    ifu_q.push_back(32'h2001);
    beat(32'h2001, 1'b0, 4'd0, 2'b00);
    flush_pipeline = 1'b1;
    cyc();
    flush_pipeline = 1'b0;
    for (int i = 2; i < 4; i++) begin
      io_master_rvalid = 1'b1;
      io_master_rdata = 32'h2000 + 32'(i);
      io_master_rlast = (i == 3);
      io_master_rid = 4'd0;
      look();
      chk("drop_rready", 64'(io_master_rready), 64'd1);
      chk("drop_rvalid", 64'(out_ifu_rvalid), 64'd0);
      cyc();
    end
    io_master_rvalid = 1'b0;
    io_master_rlast = 1'b0;

    // flush in IDLE blocks the fetch grant
    ifu_arvalid = 1'b1;
    ifu_araddr = 32'h3000_0080;
    flush_pipeline = 1'b1;
    look();
    chk("flush_idle_block", 64'(out_ifu_arready), 64'd0);
    cyc();
    flush_pipeline = 1'b0;
    look();
    chk("flush_idle_noar", 64'(io_master_arvalid), 64'd0);
    exp_ar(32'h3000_0080, 8'd3, 3'd2, 4'd0);
    chk("regrant_after_flush", 64'(out_ifu_arready), 64'd1);
    cyc();
    ifu_arvalid = 1'b0;
    ar_accept(0);
    ifu_burst(32'h3000, 1'b1);

    // ifu_lock after an IFU transaction beats a pending LSU load
    ifu_arvalid = 1'b1;
    ifu_lock = 1'b1;
    ifu_araddr = 32'h3000_00c0;
    lsu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_0030;
    lsu_rstrb = 8'hff;
    exp_ar(32'h3000_00c0, 8'd3, 3'd2, 4'd0);
    look();
    chk("lock_ifu_wins", 64'(out_ifu_arready), 64'd1);
    cyc();
    ifu_arvalid = 1'b0;
    ifu_lock = 1'b0;
    ar_accept(0);
    ifu_burst(32'h4000, 1'b1);

    // pending LSU now granted; stray rid then error response
    exp_ar(32'h8000_0030, 8'd0, 3'd3, 4'd1);
    cyc();
    lsu_arvalid = 1'b0;
    ar_accept(0);
    io_master_rvalid = 1'b1;
    io_master_rdata = 32'hBAD0_BAD0;
    io_master_rlast = 1'b1;
    io_master_rid = 4'd0;
    look();
    chk("stray_rerr", 64'(out_rerr), 64'd1);
    chk("stray_dropped", 64'(out_lsu_rvalid), 64'd0);
    cyc();
    io_master_rvalid = 1'b0;
    io_master_rlast = 1'b0;
    look();
    chk("stray_stay", 64'(io_master_rready), 64'd1);
    lsu_q.push_back(32'hCAFE_0001);
    io_master_rvalid = 1'b1;
    io_master_rdata = 32'hCAFE_0001;
    io_master_rlast = 1'b1;
    io_master_rid = 4'd1;
    io_master_rresp = 2'b10;
    look();
    chk("slverr_rerr", 64'(out_rerr), 64'd1);
    chk("slverr_rvalid", 64'(out_lsu_rvalid), 64'd1);
    cyc();
    io_master_rvalid = 1'b0;
    io_master_rlast = 1'b0;
    io_master_rresp = 2'b00;
    look();
    chk("rerr_pulse", 64'(out_rerr), 64'd0);
    cyc();

    // reset in DATA abandons the transaction; odd rstrb -> arsize 2
    lsu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_0040;
    lsu_rstrb = 8'h07;
    exp_ar(32'h8000_0040, 8'd0, 3'd2, 4'd1);
    cyc();
    lsu_arvalid = 1'b0;
    ar_accept(0);
    look();
    chk("data_rready", 64'(io_master_rready), 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    io_master_rvalid = 1'b1;
    io_master_rlast = 1'b1;
    io_master_rid = 4'd1;
    look();
    chk("rst_data_ar", 64'(io_master_arvalid), 64'd0);
    chk("rst_data_rready", 64'(io_master_rready), 64'd0);
    chk("rst_data_outs",
        64'({out_ifu_rvalid, out_lsu_rvalid, out_rerr, out_ifu_arready}),
        64'd0);
    cyc();
    io_master_rvalid = 1'b0;
    io_master_rlast = 1'b0;
    cyc();

    chk("ar_q_drained", 64'(ar_q.size()), 64'd0);
    chk("ifu_q_drained", 64'(ifu_q.size()), 64'd0);
    chk("lsu_q_drained", 64'(lsu_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
